// File: rtl/study_sequencer_pkg.sv
// Shared constants, state encoding and judging helper for the study-mode sequencer.
package study_sequencer_pkg;

  localparam int STUDY_STATE_BITS = 3;
  localparam int SCORE_BITS       = 8;
  localparam int OCTAVE_BITS      = 3;
  localparam int NOTE_BITS        = 4;
  localparam int SONG_CNT_BITS    = 8;

  typedef enum logic [STUDY_STATE_BITS-1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_JUDGE,
    ST_PLAY,
    ST_NEXT,
    ST_DONE
  } study_state_e;

  function automatic logic note_match(
    input logic [OCTAVE_BITS-1:0] hit_oct,
    input logic [NOTE_BITS-1:0]   hit_nt,
    input logic [OCTAVE_BITS-1:0] goal_oct,
    input logic [NOTE_BITS-1:0]   goal_nt
  );
    return (hit_oct == goal_oct) && (hit_nt == goal_nt);
  endfunction

endpackage

// File: rtl/study_timer.sv
// Clearable up-counter with terminal-count flag; holds at terminal count until cleared.
module study_timer #(
  parameter int          TIMER_W     = 29,
  parameter int unsigned TIMEOUT_CYC = 500000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  logic [TIMER_W-1:0] count;

  assign tc = (count == TIMER_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!tc) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/study_sequencer.sv
// Study-mode sequencer: shows the goal note, judges the player's hit, scores it and
// steps through the song until the last note has been played.
module study_sequencer
  import study_sequencer_pkg::*;
#(
  parameter int          SCORE_W     = SCORE_BITS,
  parameter int          MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 500000000,
  parameter int          TIMER_W     = 29
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     start,
  input  logic                     hit_valid,
  input  logic [OCTAVE_BITS-1:0]   hit_octave,
  input  logic [NOTE_BITS-1:0]     hit_note,
  input  logic [OCTAVE_BITS-1:0]   goal_octave,
  input  logic [NOTE_BITS-1:0]     goal_note,
  input  logic [SONG_CNT_BITS-1:0] track_len,
  input  logic                     sound_over,
  output logic [SONG_CNT_BITS-1:0] song_idx,
  output logic                     hint_en,
  output logic                     correct,
  output logic                     wrong,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       miss_cnt,
  output logic                     done
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  study_state_e             state;
  logic [RETRY_W-1:0]       retry;
  logic [OCTAVE_BITS-1:0]   hit_oct_q;
  logic [NOTE_BITS-1:0]     hit_note_q;
  logic                     sound_prev;
  logic                     sound_rise;
  logic                     timer_clr;
  logic                     timer_tc;

  // The timer only runs while waiting for a hit or for the sound; every other
  // state holds it at zero, which gives the "clear timer" on each transition.
  assign timer_clr  = !((state == ST_SHOW) || (state == ST_PLAY));
  assign sound_rise = sound_over && !sound_prev;

  study_timer #(
    .TIMER_W     (TIMER_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      song_idx   <= '0;
      score      <= '0;
      miss_cnt   <= '0;
      retry      <= '0;
      hint_en    <= 1'b0;
      correct    <= 1'b0;
      wrong      <= 1'b0;
      done       <= 1'b0;
      hit_oct_q  <= '0;
      hit_note_q <= '0;
      sound_prev <= 1'b0;
    end else begin
      sound_prev <= sound_over;
      correct    <= 1'b0;
      wrong      <= 1'b0;
      if (!en) begin
        state    <= ST_IDLE;
        song_idx <= '0;
        score    <= '0;
        miss_cnt <= '0;
        retry    <= '0;
        hint_en  <= 1'b0;
        done     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state    <= ST_SHOW;
              song_idx <= '0;
              score    <= '0;
              miss_cnt <= '0;
              retry    <= '0;
              hint_en  <= 1'b1;
              done     <= 1'b0;
            end
          end
          ST_SHOW: begin
            if (hit_valid) begin
              hit_oct_q  <= hit_octave;
              hit_note_q <= hit_note;
              hint_en    <= 1'b0;
              state      <= ST_JUDGE;
            end else if (timer_tc) begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + SCORE_W'(1);
              retry   <= '0;
              hint_en <= 1'b0;
              state   <= ST_NEXT;
            end
          end
          ST_JUDGE: begin
            if (note_match(hit_oct_q, hit_note_q, goal_octave, goal_note)) begin
              correct <= 1'b1;
              if (score != '1) score <= score + SCORE_W'(1);
              retry   <= '0;
              state   <= ST_PLAY;
            end else begin
              wrong <= 1'b1;
              if (int'(retry) + 1 < MAX_RETRY) begin
                retry   <= retry + RETRY_W'(1);
                hint_en <= 1'b1;
                state   <= ST_SHOW;
              end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + SCORE_W'(1);
                retry <= '0;
                state <= ST_PLAY;
              end
            end
          end
          ST_PLAY: begin
            if (sound_rise || timer_tc) state <= ST_NEXT;
          end
          ST_NEXT: begin
            if (song_idx >= track_len) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              song_idx <= song_idx + SONG_CNT_BITS'(1);
              hint_en  <= 1'b1;
              state    <= ST_SHOW;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_study_sequencer.sv
// Scoreboard bench for study_sequencer: stimulus queues expected judgements, a
// negedge monitor pops and checks them whenever correct/wrong pulses.
module tb_study_sequencer;
  import study_sequencer_pkg::*;

  localparam int SW = 8;

  logic                     clk = 1'b0;
  logic                     rst_n, en, start, hit_valid, sound_over;
  logic [OCTAVE_BITS-1:0]   hit_octave, goal_octave;
  logic [NOTE_BITS-1:0]     hit_note, goal_note;
  logic [SONG_CNT_BITS-1:0] track_len, song_idx;
  logic                     hint_en, correct, wrong, done;
  logic [SW-1:0]            score, miss_cnt;

  study_sequencer #(
    .SCORE_W     (SW),
    .MAX_RETRY   (3),
    .TIMEOUT_CYC (20),
    .TIMER_W     (29)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .start       (start),
    .hit_valid   (hit_valid),
    .hit_octave  (hit_octave),
    .hit_note    (hit_note),
    .goal_octave (goal_octave),
    .goal_note   (goal_note),
    .track_len   (track_len),
    .sound_over  (sound_over),
    .song_idx    (song_idx),
    .hint_en     (hint_en),
    .correct     (correct),
    .wrong       (wrong),
    .score       (score),
    .miss_cnt    (miss_cnt),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;   // {correct, wrong}
    int         idx;
    int         score;
    int         miss;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (correct || wrong)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {correct, wrong}, mon_e.kind);
        chk("pulse_idx", song_idx, mon_e.idx);
        chk("pulse_score", score, mon_e.score);
        chk("pulse_miss", miss_cnt, mon_e.miss);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] k, input int idx, input int s, input int m);
    exp_t e;
    e.kind = k; e.idx = idx; e.score = s; e.miss = m;
    sb.push_back(e);
  endtask

  task automatic hit(input int o, input int n);
    hit_octave = OCTAVE_BITS'(o);
    hit_note   = NOTE_BITS'(n);
    hit_valid  = 1'b1;
    step();
    hit_valid  = 1'b0;
  endtask

  task automatic play_done();
    sound_over = 1'b0;
    step();
    sound_over = 1'b1;
    step(2);
  endtask

  task automatic good_note(input int idx, input int s, input int m);
    push(2'b10, idx, s, m);
    hit(goal_octave, goal_note);
    step();
    play_done();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; hit_valid = 1'b0; sound_over = 1'b1;
    hit_octave = '0; hit_note = '0; goal_octave = 3'd4; goal_note = 4'd3;
    track_len = 8'd2;
    step(3);
    chk("rst_idx", song_idx, 0);
    chk("rst_score", score, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_flags", {hint_en, correct, wrong, done}, 0);
    rst_n = 1'b1;
    step();

    // 1: three correct notes, then done
    pulse_start();
    chk("t1_hint", hint_en, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_idx", song_idx, i);
      good_note(i, i + 1, 0);
    end
    chk("t1_done", done, 1);
    chk("t1_score", score, 3);
    chk("t1_miss", miss_cnt, 0);
    chk("t1_hint_off", hint_en, 0);

    // 2: three wrong hits exhaust the retries
    track_len = 8'd5;
    pulse_start();
    chk("t2_done_clr", done, 0);
    chk("t2_score_clr", score, 0);
    push(2'b01, 0, 0, 0); hit(4, 5); step();
    chk("t2_back_show", hint_en, 1);
    push(2'b01, 0, 0, 0); hit(4, 5); step();
    push(2'b01, 0, 0, 1); hit(4, 5); step();
    chk("t2_play_hint", hint_en, 0);
    play_done();
    chk("t2_idx", song_idx, 1);
    chk("t2_miss", miss_cnt, 1);
    push(2'b01, 1, 0, 1); hit(4, 5); step();
    push(2'b01, 1, 0, 1); hit(4, 5); step();
    chk("t2_retry_clr", hint_en, 1);
    good_note(1, 1, 1);

    // 3: timeout boundary, then a hit on the timeout cycle
    chk("t3_idx", song_idx, 2);
    step(19);
    chk("t3_pre_to_hint", hint_en, 1);
    chk("t3_pre_to_miss", miss_cnt, 1);
    step();
    chk("t3_to_miss", miss_cnt, 2);
    chk("t3_to_hint", hint_en, 0);
    step();
    chk("t3_to_idx", song_idx, 3);
    step(19);
    good_note(3, 2, 2);
    chk("t3_hit_wins", miss_cnt, 2);
    chk("t3_idx4", song_idx, 4);

    // 4: right note, wrong octave; timer restarts in SHOW
    push(2'b01, 4, 2, 2); hit(5, 3); step();
    chk("t4_show", hint_en, 1);
    step(19);
    chk("t4_timer_clr", hint_en, 1);
    step();
    chk("t4_to_miss", miss_cnt, 3);
    step();
    chk("t4_idx5", song_idx, 5);

    // 5: en drop mid-PLAY, async reset mid-SHOW
    push(2'b10, 5, 3, 3); hit(4, 3); step();
    en = 1'b0;
    step();
    chk("t5_en_idx", song_idx, 0);
    chk("t5_en_score", score, 0);
    chk("t5_en_miss", miss_cnt, 0);
    chk("t5_en_flags", {hint_en, correct, wrong, done}, 0);
    en = 1'b1;
    step();
    pulse_start();
    good_note(0, 1, 0);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_idx", song_idx, 0);
    chk("t5_rst_score", score, 0);
    chk("t5_rst_hint", hint_en, 0);
    step(2);
    rst_n = 1'b1;
    step();

    // 6: saturating score over 256 notes, then restart from DONE
    track_len = 8'd255;
    pulse_start();
    for (int i = 0; i < 256; i++) good_note(i, (i + 1 > 255) ? 255 : i + 1, 0);
    chk("t6_done", done, 1);
    chk("t6_score_sat", score, 255);
    chk("t6_idx", song_idx, 255);
    hit(4, 3);
    step(3);
    chk("t6_hit_ignored", done, 1);
    pulse_start();
    chk("t6_restart_score", score, 0);
    chk("t6_restart_done", done, 0);
    chk("t6_restart_idx", song_idx, 0);
    chk("t6_restart_hint", hint_en, 1);

    step(2);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
